ddd_pace_scheduler: RTL

Single-block dual-chamber (DDD-style) pacing scheduler. It replaces the separate controller and two-timer arrangement with one shared interval counter and one FSM. It sequences the atrial-escape (VA), AV-delay, pace-pulse and refractory intervals, and decides when atrial and ventricular pace pulses are issued from the sensed atrial and ventricular events. It sits between the sense front-end (sa/sv) and the pace output drivers (pa/pv).

---
 rtl/ddd_pace_scheduler.sv | 111 +++++++++++
 1 files changed

// File: rtl/ddd_pace_scheduler.sv
// Dual-chamber pacing scheduler: one shared interval counter and one FSM sequence
// VA escape, AV delay, pace pulses and the PVARP/VRP refractory windows.
module ddd_pace_scheduler #(
  parameter int unsigned AVI     = 150,
  parameter int unsigned VAI     = 850,
  parameter int unsigned PVARP   = 250,
  parameter int unsigned VRP     = 200,
  parameter int unsigned PULSE_W = 2,
  parameter int unsigned CNT_W   = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sa,
  input  logic       sv,
  output logic       pa,
  output logic       pv,
  output logic       a_refr,
  output logic       v_refr,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    WAIT_A = 2'd0,
    PACE_A = 2'd1,
    WAIT_V = 2'd2,
    PACE_V = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] AVI_LAST = CNT_W'(AVI - 1);
  localparam logic [CNT_W-1:0] VAI_LAST = CNT_W'(VAI - 1);
  localparam logic [CNT_W-1:0] PW_LAST  = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] PVARP_LD = CNT_W'(PVARP);
  localparam logic [CNT_W-1:0] VRP_LD   = CNT_W'(VRP);

  state_t           state, state_nx;
  logic [CNT_W-1:0] tmr, tmr_nx;
  logic [CNT_W-1:0] pvarp_cnt, vrp_cnt;
  logic             ld_refr;

  // Pace outputs decode straight from the state register, so async reset drops them at once.
  assign pa      = (state == PACE_A);
  assign pv      = (state == PACE_V);
  assign a_refr  = (pvarp_cnt != '0) || (state == PACE_A) || (state == WAIT_V);
  assign v_refr  = (vrp_cnt != '0) || (state == PACE_V);
  assign state_o = state;

  always_comb begin
    state_nx = state;
    tmr_nx   = tmr + CNT_W'(1);
    ld_refr  = 1'b0;
    case (state)
      WAIT_A: begin
        // A ventricular event beats a simultaneous atrial one and restarts VA timing.
        if (sv && !v_refr) begin
          tmr_nx  = '0;
          ld_refr = 1'b1;
        end else if (sa && !a_refr) begin
          tmr_nx   = '0;
          state_nx = WAIT_V;
        end else if (tmr == VAI_LAST) begin
          tmr_nx   = '0;
          state_nx = PACE_A;
        end
      end
      PACE_A: begin
        // tmr keeps running through the pulse so the AV delay counts from pace start.
        if (tmr == PW_LAST) state_nx = WAIT_V;
      end
      WAIT_V: begin
        if (sv && !v_refr) begin
          tmr_nx   = '0;
          ld_refr  = 1'b1;
          state_nx = WAIT_A;
        end else if (tmr == AVI_LAST) begin
          tmr_nx   = '0;
          ld_refr  = 1'b1;
          state_nx = PACE_V;
        end
      end
      PACE_V: begin
        if (tmr == PW_LAST) state_nx = WAIT_A;
      end
      default: state_nx = WAIT_A;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= WAIT_A;
      tmr   <= '0;
    end else begin
      state <= state_nx;
      tmr   <= tmr_nx;
    end
  end

  // Refractory windows: reload on every ventricular event, otherwise count down to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pvarp_cnt <= '0;
      vrp_cnt   <= '0;
    end else if (ld_refr) begin
      pvarp_cnt <= PVARP_LD;
      vrp_cnt   <= VRP_LD;
    end else begin
      if (pvarp_cnt != '0) pvarp_cnt <= pvarp_cnt - CNT_W'(1);
      if (vrp_cnt != '0)   vrp_cnt   <= vrp_cnt - CNT_W'(1);
    end
  end

endmodule
